io_output_bank: RTL and testbench
=================================

// Module: io_output_bank
// PURPOSE
//  Parametrised, registered output bank for the DM interface; replaces the fixed 4-bit OUTBUF wrapper.
//  Drives WIDTH pads, each with its own mode: static level, timed one-shot pulse or periodic toggle.
//  A global safe input forces every pad to a known state.
//  Sits between the register/command logic and the device OUTBUF primitives; pad_out feeds the OUTBUF D pins.
// PARAMETERS
//  WIDTH      4      number of output channels
//  CNT_W      16     width of the per-channel pulse/period counter
//  RESET_VAL  {WIDTH{1'b0}}  pad_out value while rst_n is low and after reset release
//  SAFE_VAL   {WIDTH{1'b0}}  pad_out value forced while safe is high
// PORTS
//  clk        in   1      system clock
//  rst_n      in   1      asynchronous active-low reset
//  wr_en      in   1      single-cycle command strobe
//  wr_mask    in   WIDTH  channels affected by this command (1 = apply)
//  wr_mode    in   2      0 LEVEL, 1 PULSE, 2 TOGGLE, 3 NOP
//  wr_level   in   WIDTH  per-channel level: active level (PULSE), start level (TOGGLE)
//  wr_len     in   CNT_W  pulse length or half-period in clk cycles
//  safe       in   1      force all channels to SAFE_VAL, abort activity
//  busy       out  WIDTH  channel is in PULSE or TOGGLE state
//  pad_out    out  WIDTH  registered pad drive
// BEHAVIOUR
//  - Reset: pad_out=RESET_VAL; busy=0; all channels in LEVEL state; counters=0. The async assert takes effect immediately; release is synchronous to clk.
//  - All outputs are registered. A command accepted at edge N appears on pad_out/busy after edge N (latency 1 cycle).
//  - Per-channel FSM states: LEVEL, PULSE, TOGGLE. A command updates only the channels selected by wr_mask.
//    Unselected channels continue undisturbed.
//  - LEVEL: pad=wr_level[i]; busy=0; holds indefinitely.
//  - PULSE, wr_len>0: pad=wr_level[i] for exactly wr_len cycles, then pad=~wr_level[i]; FSM returns to LEVEL and busy falls in the same cycle.
//    Counter loads wr_len-1 and decrements; the end of the pulse is detected at count 0.
//  - PULSE, wr_len==0: behaves as LEVEL with pad=~wr_level[i] (no pulse); busy stays 0.
//  - TOGGLE, wr_len>0: pad starts at wr_level[i] and inverts every wr_len cycles until re-commanded; busy=1.
//    wr_len==1 toggles every cycle.
//  - TOGGLE, wr_len==0: behaves as LEVEL with pad=wr_level[i].
//  - NOP (mode 3), or wr_mask==0: no channel changes; the strobe is ignored.
//  - Re-command of a busy channel: the new command wins immediately; the counter reloads and there is no residual pulse or extra edge.
//  - wr_len is sampled only on wr_en; later changes do not affect running channels.
//  - safe high: at the next edge pad_out=SAFE_VAL, busy=0, FSMs=LEVEL, counters cleared. wr_en is ignored while safe=1.
//    safe has priority over a simultaneous wr_en. After safe falls, pads hold SAFE_VAL until commanded.
//  - Reset mid-pulse/toggle: same as reset; there is no resumption.
//  - Counter arithmetic is unsigned CNT_W bits. The maximum pulse is 2^CNT_W-1 cycles, and the counter never wraps.
// STRUCTURE
//  - Shared package io_out_pkg holds the mode encodings (MODE_LEVEL=2'd0, MODE_PULSE=2'd1, MODE_TOGGLE=2'd2, MODE_NOP=2'd3) and the channel FSM state encoding.
//  - Sub-module io_out_chan holds one channel: its FSM, counter, pad and busy flops.
//    The top level generates WIDTH instances and gates wr_en with wr_mask[i] & ~safe.
//  - No combinational path from inputs to pad_out.
// TESTING
//  1) Reset: rst_n low mid-toggle -> pad_out=RESET_VAL and busy=0 without waiting for clk. Outputs hold after release.
//  2) LEVEL: wr_mask=4'b0101, mode 0, wr_level=4'b1111 -> one cycle later pad_out=4'b0101; channels 1 and 3 unchanged.
//  3) PULSE: ch0, level 1, wr_len=5 -> pad_out[0]=1 for exactly 5 cycles, then 0. busy[0]=1 for those 5 cycles. wr_len=0 -> pad_out[0]=0, busy=0.
//  4) TOGGLE: ch2, start level 0, wr_len=3 -> pad_out[2] gives 3 cycles of 0, then 3 of 1, repeating.
//     A re-command to LEVEL 1 mid-phase -> pad_out[2]=1 on the next cycle, busy[2]=0.
//  5) safe and wr_en asserted in the same cycle with all channels busy -> next cycle pad_out=SAFE_VAL and busy=0. The write is dropped.
//  6) Re-trigger: PULSE wr_len=10 on ch1; at cycle 4 issue PULSE wr_len=2 -> pad_out[1] high for 4+2 cycles total, then low, with no glitch.

Source files
------------

// File: rtl/io_out_pkg.sv
// rtl/io_out_pkg.sv - shared mode and channel state encodings for the output bank
package io_out_pkg;

  localparam logic [1:0] MODE_LEVEL  = 2'd0;
  localparam logic [1:0] MODE_PULSE  = 2'd1;
  localparam logic [1:0] MODE_TOGGLE = 2'd2;
  localparam logic [1:0] MODE_NOP    = 2'd3;

  typedef enum logic [1:0] {
    ST_LEVEL  = 2'd0,
    ST_PULSE  = 2'd1,
    ST_TOGGLE = 2'd2
  } chan_state_e;

endpackage

// File: rtl/io_out_chan.sv
// rtl/io_out_chan.sv - one output channel: level / one-shot pulse / periodic toggle
import io_out_pkg::*;

module io_out_chan #(
  parameter int   CNT_W    = 16,
  parameter logic RST_BIT  = 1'b0,
  parameter logic SAFE_BIT = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_en_i,
  input  logic [1:0]       mode_i,
  input  logic             level_i,
  input  logic [CNT_W-1:0] len_i,
  input  logic             safe_i,
  output logic             busy_o,
  output logic             pad_o
);

  chan_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             pad_q, pad_d;
  logic             busy_q, busy_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_LEVEL;
      cnt_q   <= '0;
      len_q   <= '0;
      pad_q   <= RST_BIT;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      pad_q   <= pad_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    pad_d   = pad_q;
    busy_d  = busy_q;
    if (safe_i) begin
      state_d = ST_LEVEL;
      cnt_d   = '0;
      len_d   = '0;
      pad_d   = SAFE_BIT;
      busy_d  = 1'b0;
    end else if (cmd_en_i && mode_i != MODE_NOP) begin
      // A new command always replaces whatever the channel was doing.
      state_d = ST_LEVEL;
      cnt_d   = '0;
      len_d   = len_i;
      busy_d  = 1'b0;
      pad_d   = level_i;
      if (mode_i == MODE_PULSE) begin
        if (len_i == '0) begin
          pad_d = ~level_i;
        end else begin
          state_d = ST_PULSE;
          cnt_d   = len_i - CNT_W'(1);
          busy_d  = 1'b1;
        end
      end else if (mode_i == MODE_TOGGLE && len_i != '0) begin
        state_d = ST_TOGGLE;
        cnt_d   = len_i - CNT_W'(1);
        busy_d  = 1'b1;
      end
    end else begin
      unique case (state_q)
        ST_PULSE: begin
          if (cnt_q == '0) begin
            pad_d   = ~pad_q;
            state_d = ST_LEVEL;
            busy_d  = 1'b0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_TOGGLE: begin
          if (cnt_q == '0) begin
            pad_d = ~pad_q;
            cnt_d = len_q - CNT_W'(1);
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy_o = busy_q;
  assign pad_o  = pad_q;

endmodule

// File: rtl/io_output_bank.sv
// rtl/io_output_bank.sv - WIDTH registered pad drivers with per-channel mode and global safe
import io_out_pkg::*;

module io_output_bank #(
  parameter int               WIDTH     = 4,
  parameter int               CNT_W     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
  parameter logic [WIDTH-1:0] SAFE_VAL  = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_mask,
  input  logic [1:0]       wr_mode,
  input  logic [WIDTH-1:0] wr_level,
  input  logic [CNT_W-1:0] wr_len,
  input  logic             safe,
  output logic [WIDTH-1:0] busy,
  output logic [WIDTH-1:0] pad_out
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    logic cmd_en;
    // safe outranks a simultaneous write, so the strobe is dropped here.
    assign cmd_en = wr_en & wr_mask[i] & ~safe;

    io_out_chan #(
      .CNT_W   (CNT_W),
      .RST_BIT (RESET_VAL[i]),
      .SAFE_BIT(SAFE_VAL[i])
    ) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .cmd_en_i(cmd_en),
      .mode_i  (wr_mode),
      .level_i (wr_level[i]),
      .len_i   (wr_len),
      .safe_i  (safe),
      .busy_o  (busy[i]),
      .pad_o   (pad_out[i])
    );
  end

endmodule

// File: tb/tb_io_output_bank.sv
// tb/tb_io_output_bank.sv - directed self-checking bench for io_output_bank
module tb_io_output_bank;

  localparam logic [3:0] SAFE = 4'b1001;
  localparam logic [3:0] RST  = 4'b0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [3:0]  wr_mask;
  logic [1:0]  wr_mode;
  logic [3:0]  wr_level;
  logic [15:0] wr_len;
  logic        safe;
  logic [3:0]  busy;
  logic [3:0]  pad_out;

  int n_cmp  = 0;
  int n_fail = 0;

  io_output_bank #(
    .WIDTH(4), .CNT_W(16), .RESET_VAL(RST), .SAFE_VAL(SAFE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_mask(wr_mask),
    .wr_mode(wr_mode), .wr_level(wr_level), .wr_len(wr_len),
    .safe(safe), .busy(busy), .pad_out(pad_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  mask;
    logic [1:0]  mode;
    logic [3:0]  level;
    logic [15:0] len;
    logic [3:0]  exp_pad;
    logic [3:0]  exp_busy;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called just after a negedge; returns at the next negedge with the command applied.
  task automatic issue(input logic [3:0] m, input logic [1:0] md, input logic [3:0] lv,
                       input logic [15:0] ln);
    wr_en = 1'b1; wr_mask = m; wr_mode = md; wr_level = lv; wr_len = ln;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  initial begin
    vecs[0]  = '{4'b0101, 2'd0, 4'b1111, 16'd0, 4'b0101, 4'b0000};
    vecs[1]  = '{4'b1010, 2'd0, 4'b1010, 16'd0, 4'b1111, 4'b0000};
    vecs[2]  = '{4'b0011, 2'd3, 4'b0000, 16'd0, 4'b1111, 4'b0000};
    vecs[3]  = '{4'b0000, 2'd0, 4'b0000, 16'd0, 4'b1111, 4'b0000};
    vecs[4]  = '{4'b0001, 2'd1, 4'b0001, 16'd0, 4'b1110, 4'b0000};
    vecs[5]  = '{4'b1000, 2'd2, 4'b0000, 16'd0, 4'b0110, 4'b0000};
    vecs[6]  = '{4'b1111, 2'd0, 4'b0000, 16'd0, 4'b0000, 4'b0000};
    vecs[7]  = '{4'b0100, 2'd1, 4'b0100, 16'd3, 4'b0100, 4'b0100};
    vecs[8]  = '{4'b0001, 2'd0, 4'b0001, 16'd0, 4'b0101, 4'b0100};
    vecs[9]  = '{4'b0010, 2'd0, 4'b0000, 16'd0, 4'b0101, 4'b0100};
    vecs[10] = '{4'b0000, 2'd3, 4'b0000, 16'd0, 4'b0001, 4'b0000};
    vecs[11] = '{4'b1111, 2'd0, 4'b0000, 16'd0, 4'b0000, 4'b0000};

    rst_n = 1'b0; wr_en = 1'b0; wr_mask = '0; wr_mode = '0; wr_level = '0;
    wr_len = '0; safe = 1'b0;
    step(2);
    chk("reset_pad", 32'(pad_out), 32'(RST));
    chk("reset_busy", 32'(busy), 0);
    rst_n = 1'b1;
    step(2);
    chk("post_release_pad", 32'(pad_out), 32'(RST));

    for (int v = 0; v < 12; v++) begin
      issue(vecs[v].mask, vecs[v].mode, vecs[v].level, vecs[v].len);
      chk($sformatf("vec%0d_pad", v), 32'(pad_out), 32'(vecs[v].exp_pad));
      chk($sformatf("vec%0d_busy", v), 32'(busy), 32'(vecs[v].exp_busy));
    end

    // Pulse of 5 on ch0, then a zero-length pulse.
    issue(4'b0001, 2'd1, 4'b0001, 16'd5);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("pulse5_hi%0d", k), 32'(pad_out[0]), 1);
      chk($sformatf("pulse5_busy%0d", k), 32'(busy[0]), 1);
      step(1);
    end
    chk("pulse5_end_pad", 32'(pad_out[0]), 0);
    chk("pulse5_end_busy", 32'(busy[0]), 0);
    step(1);
    chk("pulse5_stays_low", 32'(pad_out[0]), 0);
    issue(4'b0001, 2'd0, 4'b0001, 16'd0);
    chk("pre_len0_pad", 32'(pad_out[0]), 1);
    issue(4'b0001, 2'd1, 4'b0001, 16'd0);
    chk("len0_pad", 32'(pad_out[0]), 0);
    chk("len0_busy", 32'(busy[0]), 0);

    // Toggle ch2 half-period 3; a later wr_len change must not matter.
    issue(4'b0100, 2'd2, 4'b0000, 16'd3);
    wr_len = 16'd7;
    for (int k = 0; k < 12; k++) begin
      chk($sformatf("tog3_k%0d", k), 32'(pad_out[2]), 32'((k / 3) % 2));
      chk($sformatf("tog3_busy%0d", k), 32'(busy[2]), 1);
      step(1);
    end
    step(1);
    issue(4'b0100, 2'd0, 4'b0100, 16'd0);
    chk("tog_recmd_pad", 32'(pad_out[2]), 1);
    chk("tog_recmd_busy", 32'(busy[2]), 0);
    step(3);
    chk("tog_recmd_hold", 32'(pad_out[2]), 1);

    // Toggle every cycle on ch3.
    issue(4'b1000, 2'd2, 4'b1000, 16'd1);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("tog1_k%0d", k), 32'(pad_out[3]), 32'((k + 1) % 2));
      step(1);
    end

    // safe with a simultaneous write while every channel is busy.
    issue(4'b1111, 2'd2, 4'b1111, 16'd4);
    chk("all_busy", 32'(busy), 32'hf);
    safe = 1'b1; wr_en = 1'b1; wr_mask = 4'b1111; wr_mode = 2'd0; wr_level = 4'b0110;
    @(negedge clk);
    wr_en = 1'b0; safe = 1'b0;
    chk("safe_pad", 32'(pad_out), 32'(SAFE));
    chk("safe_busy", 32'(busy), 0);
    step(6);
    chk("safe_hold_pad", 32'(pad_out), 32'(SAFE));
    chk("safe_hold_busy", 32'(busy), 0);

    // Re-trigger: pulse 10 on ch1, replaced by pulse 2 at its fifth cycle.
    issue(4'b1111, 2'd0, 4'b0000, 16'd0);
    issue(4'b0010, 2'd1, 4'b0010, 16'd10);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("retrig_a%0d", k), 32'(pad_out[1]), 1);
      step(1);
    end
    issue(4'b0010, 2'd1, 4'b0010, 16'd2);
    chk("retrig_b0", 32'(pad_out[1]), 1);
    step(1);
    chk("retrig_b1", 32'(pad_out[1]), 1);
    step(1);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("retrig_low%0d", k), 32'(pad_out[1]), 0);
      chk($sformatf("retrig_busy%0d", k), 32'(busy[1]), 0);
      step(1);
    end

    // Asynchronous reset in the middle of a toggle.
    issue(4'b0001, 2'd2, 4'b0001, 16'd2);
    step(1);
    chk("pre_reset_busy", 32'(busy[0]), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_pad", 32'(pad_out), 32'(RST));
    chk("async_reset_busy", 32'(busy), 0);
    step(2);
    rst_n = 1'b1;
    step(5);
    chk("reset_no_resume_pad", 32'(pad_out), 32'(RST));
    chk("reset_no_resume_busy", 32'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
